user_obi_sbr_demux: RTL and testbench

Parametrised OBI subordinate-side demultiplexer for the user domain. It decodes the incoming address against a runtime rule table and routes the request to one of NumPorts manager ports. Unmapped or disabled targets go to an integrated error responder. It tracks outstanding transactions, keeps responses in order, and counts and flags decode errors for software.

---
 rtl/user_obi_sbr_demux.sv | 201 ++++++++++++++++++++
 tb/tb_user_obi_sbr_demux.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_sbr_demux.sv
`default_nettype none
// ============================================================================
//  Module   : user_obi_sbr_demux (with user_obi_sbr_demux_pkg)
//  Purpose  : OBI subordinate-side demultiplexer. Decodes the request address
//             against a runtime rule table, forwards the request to one of
//             NumPorts manager ports or to an internal error responder, keeps
//             responses in order by allowing only one target in flight, and
//             counts / flags error responses.
//  Ports    : clk_i, rst_ni        clock, asynchronous active-low reset
//             sbr_req_i/sbr_rsp_o  upstream OBI request / response
//             mgr_req_o/mgr_rsp_i  downstream OBI requests / responses
//             addr_map_i           rules {idx, start_addr, end_addr(excl.)}
//             port_en_i            per-port enable (disabled -> error)
//             err_clr_i            synchronous clear of err_cnt_o
//             err_cnt_o            saturating error response count
//             err_irq_o            one-cycle pulse per error response
//  Revision : 1.0 - initial release
// ============================================================================

package user_obi_sbr_demux_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 4;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_t;

    typedef struct packed {
        obi_a_t a;
        logic   req;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_t;

    typedef struct packed {
        obi_r_t r;
        logic   gnt;
        logic   rvalid;
    } obi_rsp_t;

    typedef struct packed {
        logic [31:0]          idx;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
    } rule_t;
endpackage

module user_obi_sbr_demux #(
    parameter type         obi_req_t   = user_obi_sbr_demux_pkg::obi_req_t,
    parameter type         obi_rsp_t   = user_obi_sbr_demux_pkg::obi_rsp_t,
    parameter type         rule_t      = user_obi_sbr_demux_pkg::rule_t,
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned NumRules    = 4,
    parameter int unsigned NumMaxTrans = 4,
    parameter logic [31:0] ErrRspData  = 32'hBADCAB1E,
    parameter int unsigned ErrCntWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t               sbr_req_i,
    output obi_rsp_t               sbr_rsp_o,
    output obi_req_t               mgr_req_o  [NumPorts],
    input  obi_rsp_t               mgr_rsp_i  [NumPorts],
    input  rule_t                  addr_map_i [NumRules],
    input  logic [NumPorts-1:0]    port_en_i,
    input  logic                   err_clr_i,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    output logic                   err_irq_o
);

    // Target encoding: 0..NumPorts-1 are real ports, NumPorts is the error responder.
    localparam int unsigned            c_SEL_W     = $clog2(NumPorts + 1);
    localparam int unsigned            c_CNT_W     = $clog2(NumMaxTrans + 1);
    localparam logic [c_SEL_W-1:0]     c_SEL_ERR   = c_SEL_W'(NumPorts);
    localparam logic [c_CNT_W-1:0]     c_MAX_TRANS = c_CNT_W'(NumMaxTrans);

    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_SEL_W-1:0]     r_sel;
    obi_rsp_t               r_err_rsp;
    logic [ErrCntWidth-1:0] r_err_cnt;

    logic               w_hit;
    logic [31:0]        w_hit_idx;
    logic [c_SEL_W-1:0] w_tgt;
    logic               w_cnt_zero;
    logic               w_can_issue;
    logic               w_tgt_gnt;
    logic               w_gnt;
    logic               w_hs;
    logic               w_rvalid;
    logic               w_err_event;
    obi_rsp_t           w_rsp;

    // Address decode: the lowest-indexed matching rule wins; a miss, an
    // out-of-range port index or a disabled port all fall through to ERR.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int r = 0; r < NumRules; r++) begin
            if (!w_hit &&
                (sbr_req_i.a.addr >= addr_map_i[r].start_addr) &&
                (sbr_req_i.a.addr <  addr_map_i[r].end_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = addr_map_i[r].idx;
            end
        end
        w_tgt = c_SEL_ERR;
        if (w_hit) begin
            for (int p = 0; p < NumPorts; p++) begin
                if ((w_hit_idx == 32'(p)) && port_en_i[p]) begin
                    w_tgt = c_SEL_W'(p);
                end
            end
        end
    end

    // Only one target may have transactions in flight, so responses can
    // never overtake each other across ports.
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_can_issue = (r_cnt < c_MAX_TRANS) && (w_cnt_zero || (w_tgt == r_sel));

    // Request fan-out and grant selection by the current decode target.
    always_comb begin
        w_tgt_gnt = 1'b1;   // error responder accepts immediately
        for (int p = 0; p < NumPorts; p++) begin
            mgr_req_o[p]     = sbr_req_i;
            mgr_req_o[p].req = sbr_req_i.req && w_can_issue && (w_tgt == c_SEL_W'(p));
            if (w_tgt == c_SEL_W'(p)) begin
                w_tgt_gnt = mgr_rsp_i[p].gnt;
            end
        end
        w_gnt = sbr_req_i.req && w_can_issue && w_tgt_gnt;
    end

    // Response mux by the target of the outstanding transactions. A response
    // with nothing outstanding is not passed upstream.
    always_comb begin
        w_rsp = r_err_rsp;
        for (int p = 0; p < NumPorts; p++) begin
            if (r_sel == c_SEL_W'(p)) begin
                w_rsp = mgr_rsp_i[p];
            end
        end
        w_rvalid         = w_rsp.rvalid && !w_cnt_zero;
        sbr_rsp_o        = w_rsp;
        sbr_rsp_o.gnt    = w_gnt;
        sbr_rsp_o.rvalid = w_rvalid;
    end

    assign w_hs        = sbr_req_i.req && w_gnt;
    assign w_err_event = w_rvalid && (r_sel == c_SEL_ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_sel     <= '0;
            r_err_rsp <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_sel <= w_tgt;
            end

            case ({w_hs, w_rvalid})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase

            // One-entry error pipeline: refilled every accepted ERR request,
            // so back-to-back error accesses respond at full rate.
            r_err_rsp <= '0;
            if (w_hs && (w_tgt == c_SEL_ERR)) begin
                r_err_rsp.rvalid  <= 1'b1;
                r_err_rsp.r.err   <= 1'b1;
                r_err_rsp.r.rdata <= ErrRspData;
                r_err_rsp.r.rid   <= sbr_req_i.a.aid;
            end

            if (err_clr_i) begin
                r_err_cnt <= '0;
            end else if (w_err_event && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ErrCntWidth'(1);
            end
        end
    end

    assign err_cnt_o = r_err_cnt;
    assign err_irq_o = w_err_event;

endmodule
`default_nettype wire

// File: tb/tb_user_obi_sbr_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_obi_sbr_demux
//  Purpose  : Directed self-checking bench for user_obi_sbr_demux. Each
//             downstream port is modelled as an always-granting subordinate
//             with a 2-cycle response latency, a response stall control and
//             rdata = addr ^ 32'hFFFF_0000 ^ port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_user_obi_sbr_demux;
    import user_obi_sbr_demux_pkg::*;

    localparam int NP  = 4;
    localparam int NR  = 4;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obi_req_t   sbr_req;
    obi_rsp_t   sbr_rsp;
    obi_req_t   mgr_req [NP];
    obi_rsp_t   mgr_rsp [NP];
    rule_t      amap    [NR];
    logic [NP-1:0] port_en;
    logic          err_clr;
    logic [1:0]    err_cnt;
    logic          err_irq;
    logic [NP-1:0] stall;
    logic          mon1;
    logic          saw1;

    int n_chk  = 0;
    int n_fail = 0;

    user_obi_sbr_demux #(
        .NumPorts    (NP),
        .NumRules    (NR),
        .NumMaxTrans (4),
        .ErrRspData  (32'hBADCAB1E),
        .ErrCntWidth (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sbr_req_i  (sbr_req),
        .sbr_rsp_o  (sbr_rsp),
        .mgr_req_o  (mgr_req),
        .mgr_rsp_i  (mgr_rsp),
        .addr_map_i (amap),
        .port_en_i  (port_en),
        .err_clr_i  (err_clr),
        .err_cnt_o  (err_cnt),
        .err_irq_o  (err_irq)
    );

    // ---------------- downstream subordinate models ----------------
    logic [31:0] q_addr [NP][8];
    logic [3:0]  q_id   [NP][8];
    int unsigned q_due  [NP][8];
    logic [2:0]  wp [NP];
    logic [2:0]  rp [NP];
    logic [3:0]  qn [NP];
    int unsigned cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int p = 0; p < NP; p++) begin
                wp[p] <= '0;
                rp[p] <= '0;
                qn[p] <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int p = 0; p < NP; p++) begin
                if (mgr_req[p].req && mgr_rsp[p].gnt) begin
                    q_addr[p][wp[p]] <= mgr_req[p].a.addr;
                    q_id[p][wp[p]]   <= mgr_req[p].a.aid;
                    q_due[p][wp[p]]  <= cyc + LAT;
                    wp[p]            <= wp[p] + 3'd1;
                end
                if (mgr_rsp[p].rvalid) begin
                    rp[p] <= rp[p] + 3'd1;
                end
                qn[p] <= qn[p] + {3'b0, (mgr_req[p].req && mgr_rsp[p].gnt)}
                               - {3'b0, mgr_rsp[p].rvalid};
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            mgr_rsp[p]         = '0;
            mgr_rsp[p].gnt     = 1'b1;
            mgr_rsp[p].rvalid  = (qn[p] != 4'd0) && !stall[p] && (cyc >= q_due[p][rp[p]]);
            mgr_rsp[p].r.rdata = q_addr[p][rp[p]] ^ 32'hFFFF_0000 ^ 32'(p);
            mgr_rsp[p].r.rid   = q_id[p][rp[p]];
        end
    end

    // Sticky monitor: did port 1 ever see a request while mon1 was set?
    always_ff @(posedge clk) begin
        if (!mon1)                saw1 <= 1'b0;
        else if (mgr_req[1].req)  saw1 <= 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic [3:0] id);
        sbr_req.req     = r;
        sbr_req.a.addr  = a;
        sbr_req.a.aid   = id;
        sbr_req.a.we    = 1'b0;
        sbr_req.a.be    = 4'hF;
        sbr_req.a.wdata = 32'h0;
    endtask

    // Called at a negedge; waits until rvalid or the budget runs out.
    task automatic wait_rvalid(input string tag, input int maxc);
        int k;
        k = 0;
        while (!sbr_rsp.rvalid && k < maxc) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(sbr_rsp.rvalid), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] exp_rd [6];
    int ngr, nrsp, maxcnt, nirq, ngnt, k;

    initial begin
        exp_rd = '{32'hDFFF_0100, 32'hDFFF_0104, 32'hDFFF_0108,
                   32'hDFFF_010C, 32'hDFFF_0110, 32'hDFFF_0114};
        drive(1'b0, 32'h0, 4'h0);
        port_en = 4'hF;
        err_clr = 1'b0;
        stall   = '0;
        mon1    = 1'b0;
        amap[0] = '{idx: 32'd0, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000};
        amap[1] = '{idx: 32'd1, start_addr: 32'h2000_1000, end_addr: 32'h2000_2000};
        amap[2] = '{idx: 32'd2, start_addr: 32'h0, end_addr: 32'h0};
        amap[3] = '{idx: 32'd3, start_addr: 32'h0, end_addr: 32'h0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- reset state ----
        @(negedge clk);
        check_eq("rst_rvalid",  32'(sbr_rsp.rvalid), 32'(0));
        check_eq("rst_gnt",     32'(sbr_rsp.gnt),    32'(0));
        check_eq("rst_err_cnt", 32'(err_cnt),        32'(0));
        check_eq("rst_irq",     32'(err_irq),        32'(0));
        check_eq("rst_cnt",     32'(dut.r_cnt),      32'(0));
        check_eq("rst_mgr0req", 32'(mgr_req[0].req), 32'(0));

        // ---- port0 read ----
        @(posedge clk); #1 drive(1'b1, 32'h2000_0010, 4'd1);
        @(negedge clk);
        check_eq("p0_req0", 32'(mgr_req[0].req), 32'(1));
        check_eq("p0_req1", 32'(mgr_req[1].req), 32'(0));
        check_eq("p0_gnt",  32'(sbr_rsp.gnt),    32'(1));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        check_eq("p0_cnt1",  32'(dut.r_cnt),      32'(1));
        check_eq("p0_early", 32'(sbr_rsp.rvalid), 32'(0));
        @(posedge clk); @(negedge clk);
        check_eq("p0_rvalid", 32'(sbr_rsp.rvalid),  32'(1));
        check_eq("p0_rdata",  sbr_rsp.r.rdata,      32'hDFFF_0010);
        check_eq("p0_rid",    32'(sbr_rsp.r.rid),   32'(1));
        check_eq("p0_err",    32'(sbr_rsp.r.err),   32'(0));
        @(posedge clk); @(negedge clk);
        check_eq("p0_cnt0", 32'(dut.r_cnt), 32'(0));

        // ---- unmapped address -> error responder ----
        @(posedge clk); #1 drive(1'b1, 32'h3000_0000, 4'd3);
        @(negedge clk);
        check_eq("err_gnt",  32'(sbr_rsp.gnt),    32'(1));
        check_eq("err_req0", 32'(mgr_req[0].req), 32'(0));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        check_eq("err_rvalid", 32'(sbr_rsp.rvalid), 32'(1));
        check_eq("err_flag",   32'(sbr_rsp.r.err),  32'(1));
        check_eq("err_rdata",  sbr_rsp.r.rdata,     32'hBADCAB1E);
        check_eq("err_rid",    32'(sbr_rsp.r.rid),  32'(3));
        check_eq("err_irq",    32'(err_irq),        32'(1));
        @(posedge clk); @(negedge clk);
        check_eq("err_cnt1",   32'(err_cnt),        32'(1));
        check_eq("err_irq_off",32'(err_irq),        32'(0));
        check_eq("err_cnt0",   32'(dut.r_cnt),      32'(0));

        // ---- disabled port1 -> error ----
        @(posedge clk); #1 port_en = 4'b1101; mon1 = 1'b1; drive(1'b1, 32'h2000_1004, 4'd5);
        @(negedge clk);
        check_eq("dis_gnt",  32'(sbr_rsp.gnt),    32'(1));
        check_eq("dis_req1", 32'(mgr_req[1].req), 32'(0));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        check_eq("dis_err", 32'(sbr_rsp.r.err),  32'(1));
        check_eq("dis_rid", 32'(sbr_rsp.r.rid),  32'(5));
        @(posedge clk); @(negedge clk);
        check_eq("dis_err_cnt", 32'(err_cnt), 32'(2));
        check_eq("dis_saw1",    32'(saw1),    32'(0));
        @(posedge clk); #1 mon1 = 1'b0; port_en = 4'hF;

        // ---- outstanding limit: 6 reads, responses stalled ----
        stall[0] = 1'b1; ngr = 0; nrsp = 0; maxcnt = 0;
        drive(1'b1, 32'h2000_0100, 4'd6);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sbr_rsp.gnt) ngr++;
            if (int'(dut.r_cnt) > maxcnt) maxcnt = int'(dut.r_cnt);
            @(posedge clk); #1 sbr_req.a.addr = 32'h2000_0100 + 32'(4 * ngr);
        end
        @(negedge clk);
        check_eq("lim_grants", 32'(ngr),         32'(4));
        check_eq("lim_gnt0",   32'(sbr_rsp.gnt), 32'(0));
        check_eq("lim_cnt4",   32'(dut.r_cnt),   32'(4));
        @(posedge clk); #1 stall[0] = 1'b0;
        k = 0;
        while ((ngr < 6 || nrsp < 6) && k < 40) begin
            @(negedge clk);
            if (sbr_rsp.rvalid) begin
                if (nrsp < 6) check_eq("lim_order", sbr_rsp.r.rdata, exp_rd[nrsp]);
                else          check_eq("lim_extra", 32'(nrsp), 32'(5));
                nrsp++;
            end
            if (sbr_rsp.gnt) ngr++;
            if (int'(dut.r_cnt) > maxcnt) maxcnt = int'(dut.r_cnt);
            @(posedge clk); #1;
            if (ngr >= 6) sbr_req.req = 1'b0;
            else          sbr_req.a.addr = 32'h2000_0100 + 32'(4 * ngr);
            k++;
        end
        check_eq("lim_total_gnt", 32'(ngr),            32'(6));
        check_eq("lim_total_rsp", 32'(nrsp),           32'(6));
        check_eq("lim_maxcnt",    32'(maxcnt <= 4),    32'(1));
        @(negedge clk);
        check_eq("lim_cnt_end",   32'(dut.r_cnt),      32'(0));

        // ---- target switch blocked until drain ----
        @(posedge clk); #1 stall[0] = 1'b1; drive(1'b1, 32'h2000_0020, 4'd2);
        @(negedge clk);
        check_eq("sw_gnt_p0", 32'(sbr_rsp.gnt), 32'(1));
        @(posedge clk); #1 drive(1'b1, 32'h2000_1008, 4'd4);
        @(negedge clk);
        check_eq("sw_block",   32'(sbr_rsp.gnt),    32'(0));
        check_eq("sw_block_r", 32'(mgr_req[1].req), 32'(0));
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check_eq("sw_block2", 32'(sbr_rsp.gnt), 32'(0));
        @(posedge clk); #1 stall[0] = 1'b0;
        @(negedge clk);
        check_eq("sw_p0_rsp",   32'(sbr_rsp.rvalid), 32'(1));
        check_eq("sw_p0_rdata", sbr_rsp.r.rdata,     32'hDFFF_0020);
        check_eq("sw_gnt_rsp",  32'(sbr_rsp.gnt),    32'(0));
        @(posedge clk); @(negedge clk);
        check_eq("sw_gnt_p1", 32'(sbr_rsp.gnt),    32'(1));
        check_eq("sw_req_p1", 32'(mgr_req[1].req), 32'(1));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        wait_rvalid("sw_p1_timeout", 6);
        check_eq("sw_p1_rdata", sbr_rsp.r.rdata,    32'hDFFF_1009);
        check_eq("sw_p1_rid",   32'(sbr_rsp.r.rid), 32'(4));

        // ---- back-to-back errors, saturation at 3 ----
        @(posedge clk); #1 drive(1'b1, 32'h3000_0000, 4'd7);
        nirq = 0; ngnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (err_irq)     nirq++;
            if (sbr_rsp.gnt) ngnt++;
            @(posedge clk); #1;
            if (c == 4) drive(1'b0, 32'h0, 4'd0);
        end
        check_eq("sat_gnts", 32'(ngnt), 32'(5));
        check_eq("sat_irqs", 32'(nirq), 32'(5));
        @(negedge clk);
        check_eq("sat_cnt", 32'(err_cnt), 32'(3));
        @(posedge clk); #1 drive(1'b1, 32'h3000_0000, 4'd1);
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0); err_clr = 1'b1;
        @(negedge clk);
        check_eq("clr_irq", 32'(err_irq), 32'(1));
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_cnt", 32'(err_cnt), 32'(0));

        // ---- asynchronous reset mid-transaction ----
        @(posedge clk); #1 drive(1'b1, 32'h3000_0000, 4'd0);
        @(posedge clk); #1 stall[0] = 1'b1; drive(1'b1, 32'h2000_0030, 4'd2);
        @(negedge clk);
        check_eq("ar_gated", 32'(sbr_rsp.gnt), 32'(0));
        @(posedge clk); @(negedge clk);
        check_eq("ar_gnt", 32'(sbr_rsp.gnt), 32'(1));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        check_eq("ar_cnt1",    32'(dut.r_cnt), 32'(1));
        check_eq("ar_err_cnt", 32'(err_cnt),   32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_cnt0",    32'(dut.r_cnt),      32'(0));
        check_eq("ar_sel0",    32'(dut.r_sel),      32'(0));
        check_eq("ar_errcnt0", 32'(err_cnt),        32'(0));
        check_eq("ar_irq0",    32'(err_irq),        32'(0));
        check_eq("ar_rvalid0", 32'(sbr_rsp.rvalid), 32'(0));
        check_eq("ar_req0",    32'(mgr_req[0].req), 32'(0));
        @(posedge clk); #1 rst_n = 1'b1; stall = '0;
        @(posedge clk); #1 drive(1'b1, 32'h2000_1000, 4'd9);
        @(negedge clk);
        check_eq("post_gnt", 32'(sbr_rsp.gnt), 32'(1));
        @(posedge clk); #1 drive(1'b0, 32'h0, 4'd0);
        @(negedge clk);
        wait_rvalid("post_timeout", 6);
        check_eq("post_rdata", sbr_rsp.r.rdata,    32'hDFFF_1001);
        check_eq("post_rid",   32'(sbr_rsp.r.rid), 32'(9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
